descrambler_rx: RTL and testbench
=================================

# descrambler_rx

Receive-side descrambler for the 802.11a PHY, the counterpart of the transmit scrambler (x^7 + x^4 + 1, state shifts left, feedback bit = s[6]^s[3]). The transmitter's seed is never sent, so the block recovers the descrambler state from the first 7 received bits of the SERVICE field, which are zero before scrambling. It then descrambles the rest of the frame bit-serially and checks the 9 reserved SERVICE bits. It sits between the Viterbi decoder output and the PSDU deframer.

## Interface
Parameters:
- LEN_W, 16, width of the frame bit-count input.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a new frame and latches num_bits.
- num_bits  input  LEN_W  total frame bits, SERVICE bits included; sampled only when start=1.
- x  input  1  scrambled input bit.
- in_valid  input  1  x is valid this cycle.
- x_descrambled  output  1  descrambled bit (registered).
- valid  output  1  x_descrambled is valid.
- last  output  1  asserted together with valid on the final bit of the frame.
- lock_state  output  7  recovered scrambler state after 7 bits.
- locked  output  1  lock_state is valid for the current frame.
- service_err  output  1  sticky flag; a descrambled SERVICE bit 7..15 was 1.

## Operation
- States: IDLE, SEED, RUN.
- A 7-bit register s and a bit counter cnt (LEN_W bits) are maintained.
- IDLE:
  - In-valid bits are ignored; valid stays 0.
  - start with num_bits≠0 → SEED; latch num_bits, set cnt=0, clear locked and service_err.
  - start with num_bits=0 → remain IDLE; nothing else changes.
- SEED (cnt 0..6), per accepted bit:
  - s ← {s[5:0], x}, because an all-zero payload makes the received bit equal the scrambler bit.
  - x_descrambled ← 0.
  - On the 7th bit (cnt=6): locked←1, lock_state←{s[5:0],x}, next state RUN.
- RUN, per accepted bit:
  - p = s[6]^s[3]; x_descrambled ← x^p; s ← {s[5:0], p}.
  - For cnt 7..15, if x^p=1 then service_err←1.
- Every accepted bit: valid←1, cnt←cnt+1.
- Frame end: when cnt = latched num_bits−1, last←1 with that bit and next state IDLE. This also applies when num_bits<7, so the frame can end inside SEED with locked left 0.
- A cycle without in_valid does not advance state, s or cnt; valid←0 and last←0.
- start in SEED or RUN aborts the current frame: same actions as start in IDLE, with no last for the aborted frame.
- start together with in_valid: that bit is bit 0 of the new frame.
- lock_state, locked and service_err hold their values after the frame until the next start.

## Timing
- Latency: exactly 1 cycle. valid, x_descrambled and last appear on the edge after the input bit is sampled.
- Throughput: 1 bit per clock; back-to-back in_valid is supported with no bubbles.
- locked rises on the same edge that emits descrambled bit 6.
- service_err can rise on the edges emitting bits 7..15 only.
- Reset (asynchronous, any time, including mid-frame):
  - State←IDLE; s, cnt, lock_state←0.
  - x_descrambled, valid, last, locked, service_err←0.
  - The first rising edge after reset release behaves as in IDLE.
- cnt never wraps: num_bits ≤ 2^LEN_W−1 and the frame ends at num_bits−1.

## Test plan
- Seed recovery: TX seed 7'b1111111, 32 zero data bits scrambled (input 0000111 011110010 1100100…), num_bits=32 → 32 zero outputs, locked after bit 6, lock_state=7'b0000111, service_err=0, last on output 32.
- Random seeds: 20 frames of random payload through the scrambler model, num_bits 16..1000, random in_valid gaps → output equals source bits, 1-cycle latency, last exactly once per frame.
- SERVICE check: bit 10 of the source set to 1 → service_err=1 from the edge emitting bit 10 until the next start, with the data still correct.
- Abort: start reasserted at cnt=50 of a 200-bit frame → no last for frame 1, locked cleared, frame 2 decodes correctly; also cover start together with in_valid.
- Short frames: num_bits=0 → no outputs, stays IDLE; num_bits=5 → 5 zero outputs, last on the 5th, locked=0.
- Reset mid-RUN at bit 30 → all outputs 0 asynchronously; the next frame decodes correctly.

Source files
------------

// File: rtl/descrambler_rx.sv
// descrambler_rx
// Receive-side descrambler for the 802.11a PHY (x^7 + x^4 + 1).
// The transmitter seed is never sent. Bits 0..6 of SERVICE are zero before
// scrambling, so the first 7 received bits are the raw scrambler sequence.
// Shifting those 7 bits in reproduces the transmitter state. After that the
// block runs the same LFSR and XORs it out of the stream.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         pulse; begins a frame, latches num_bits (aborts any frame)
//   num_bits      total frame bits including SERVICE; 0 means no frame
//   x, in_valid   scrambled input bit and its qualifier
//   x_descrambled registered descrambled bit (forced 0 while seeding)
//   valid, last   output qualifier and final-bit marker
//   lock_state    recovered scrambler state after 7 bits
//   locked        lock_state is valid for the current frame
//   service_err   sticky: a descrambled reserved SERVICE bit (7..15) was 1
module descrambler_rx #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] num_bits,
  input  logic             x,
  input  logic             in_valid,
  output logic             x_descrambled,
  output logic             valid,
  output logic             last,
  output logic [6:0]       lock_state,
  output logic             locked,
  output logic             service_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEED = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]       state;
  logic [6:0]       s;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] nb;

  // Effective state/count/length for this cycle. A start takes effect
  // immediately, so a bit arriving with start is bit 0 of the new frame.
  logic [1:0]       st_e;
  logic [LEN_W-1:0] cnt_e;
  logic [LEN_W-1:0] nb_e;
  logic             p;
  logic             d;
  logic             accept;
  logic             frame_end;
  logic             svc_win;
  logic             new_frame;

  always_comb begin
    new_frame = start && (num_bits != '0);
    st_e  = state;
    cnt_e = cnt;
    nb_e  = nb;
    if (start) begin
      // start with a zero length drops any frame in progress but
      // leaves the count, length and status untouched
      st_e = new_frame ? SEED : IDLE;
      if (new_frame) begin
        cnt_e = '0;
        nb_e  = num_bits;
      end
    end
    p         = s[6] ^ s[3];
    d         = x ^ p;
    accept    = in_valid && (st_e != IDLE);
    frame_end = (cnt_e == nb_e - LEN_W'(1));
    svc_win   = (cnt_e >= LEN_W'(7)) && (cnt_e <= LEN_W'(15));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      s             <= '0;
      cnt           <= '0;
      nb            <= '0;
      lock_state    <= '0;
      x_descrambled <= 1'b0;
      valid         <= 1'b0;
      last          <= 1'b0;
      locked        <= 1'b0;
      service_err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      last  <= 1'b0;
      state <= st_e;
      cnt   <= cnt_e;
      nb    <= nb_e;
      if (new_frame) begin
        locked      <= 1'b0;
        service_err <= 1'b0;
      end
      if (accept) begin
        valid <= 1'b1;
        cnt   <= cnt_e + LEN_W'(1);
        if (st_e == SEED) begin
          // The payload is zero here, so the received bit is the
          // scrambler bit itself.
          s             <= {s[5:0], x};
          x_descrambled <= 1'b0;
          if (cnt_e == LEN_W'(6)) begin
            locked     <= 1'b1;
            lock_state <= {s[5:0], x};
            state      <= RUN;
          end
        end else begin
          s             <= {s[5:0], p};
          x_descrambled <= d;
          if (svc_win && d)
            service_err <= 1'b1;
        end
        // The frame end overrides SEED->RUN for frames shorter than 8 bits.
        if (frame_end) begin
          last  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_descrambler_rx.sv
module tb_descrambler_rx;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] num_bits;
  logic             x;
  logic             in_valid;
  logic             x_descrambled;
  logic             valid;
  logic             last;
  logic [6:0]       lock_state;
  logic             locked;
  logic             service_err;

  descrambler_rx #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_bits(num_bits),
    .x(x), .in_valid(in_valid), .x_descrambled(x_descrambled),
    .valid(valid), .last(last), .lock_state(lock_state),
    .locked(locked), .service_err(service_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       lst;
    logic       lck;
    logic       serr;
    logic       chk;
    logic [6:0] lv;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic       src [0:1023];
  logic       seq [0:1039];
  logic [6:0] f_lv;
  logic       f_serr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid output.
  always @(negedge clk) begin
    if (reset) begin
      if (valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("data", x_descrambled, e.b);
          chk("last", last, e.lst);
          chk("locked", locked, e.lck);
          chk("service_err", service_err, e.serr);
          chk("latency", cyc, e.cyc + 1);
          if (e.chk) chk("lock_state", lock_state, e.lv);
        end
      end else begin
        chk("last_without_valid", last, 0);
      end
    end
  end

  // Reference: the scrambler is a maximal-length sequence seq[] where
  // seq[n+7] = seq[n] ^ seq[n+3]. Scrambled bit n = src[n] ^ seq[n+7].
  task automatic send_frame(input logic [6:0] seed, input int nb, input int gap,
                            input int abort_at, input bit sv);
    int  n;
    int  lim;
    bit  first;
    exp_t t;
    for (int k = 0; k < 7; k++) seq[k] = seed[6-k];
    for (int k = 0; k < nb; k++) seq[k+7] = seq[k] ^ seq[k+3];
    for (int k = 0; k < 7; k++) f_lv[6-k] = seq[7+k];
    f_serr = 1'b0;
    lim   = (abort_at >= 0) ? abort_at : nb;
    n     = 0;
    first = 1'b1;
    while (n < lim) begin
      @(posedge clk); #1;
      start    = first;
      num_bits = first ? LEN_W'(nb) : LEN_W'($urandom);
      if (first && !sv) in_valid = 1'b0;
      else if (first)   in_valid = 1'b1;
      else              in_valid = ($urandom_range(0, 99) >= gap);
      first = 1'b0;
      if (in_valid) begin
        x = src[n] ^ seq[n+7];
        if (n >= 7 && n <= 15 && src[n]) f_serr = 1'b1;
        t.b    = (n < 7) ? 1'b0 : src[n];
        t.lst  = (n == nb - 1);
        t.lck  = (n >= 6);
        t.serr = f_serr;
        t.chk  = (n == nb - 1) && (nb >= 7);
        t.lv   = f_lv;
        t.cyc  = cyc;
        q.push_back(t);
        n++;
      end else begin
        x = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk); k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  // Random in_valid while no frame is active: must produce nothing.
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'($urandom); x = 1'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic post_check(input bit lck, input logic [6:0] lv, input bit serr);
    idle(4);
    chk("hold_locked", locked, lck);
    if (lck) chk("hold_lock_state", lock_state, lv);
    chk("hold_service_err", service_err, serr);
  endtask

  task automatic rand_src(input int nb);
    for (int k = 0; k < nb; k++) src[k] = (k < 7) ? 1'b0 : 1'($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    reset = 1'b0; start = 1'b0; num_bits = '0; x = 1'b0; in_valid = 1'b0;
    #23;
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_locked", locked, 0);
    chk("rst_serr", service_err, 0);
    chk("rst_lock_state", lock_state, 0);
    chk("rst_data", x_descrambled, 0);
    reset = 1'b1;

    // Seed recovery with all-ones seed, zero payload.
    for (int k = 0; k < 1024; k++) src[k] = 1'b0;
    send_frame(7'h7f, 32, 0, -1, 1'b0);
    drain();
    chk("seed_vector_lock", f_lv, 7'b0000111);
    post_check(1'b1, 7'b0000111, 1'b0);

    // Random seeds, payloads, lengths and gaps.
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(16, 1000);
      rand_src(nb);
      send_frame(7'($urandom_range(1, 127)), nb, $urandom_range(0, 40), -1,
                 1'($urandom_range(0, 1)));
      drain();
      post_check(1'b1, f_lv, f_serr);
      idle($urandom_range(0, 5));
    end

    // Reserved SERVICE bit 10 set.
    for (int k = 0; k < 1024; k++) src[k] = 1'b0;
    src[10] = 1'b1;
    for (int k = 16; k < 64; k++) src[k] = 1'($urandom);
    send_frame(7'h35, 64, 20, -1, 1'b0);
    drain();
    post_check(1'b1, f_lv, 1'b1);

    // Abort at bit 50, then restart with start and in_valid together.
    rand_src(200);
    send_frame(7'h4b, 200, 10, 50, 1'b0);
    drain();
    rand_src(300);
    send_frame(7'h19, 300, 10, -1, 1'b1);
    drain();
    post_check(1'b1, f_lv, f_serr);

    // num_bits = 0: nothing emitted, status unchanged.
    @(posedge clk); #1;
    start = 1'b1; num_bits = '0; in_valid = 1'b1; x = 1'b1;
    idle(10);
    chk("zero_len_locked_held", locked, 1);
    chk("zero_len_lock_state_held", lock_state, f_lv);

    // num_bits = 5: ends inside the seed phase.
    for (int k = 0; k < 8; k++) src[k] = 1'b0;
    send_frame(7'h5a, 5, 0, -1, 1'b0);
    drain();
    post_check(1'b0, 7'h00, 1'b0);

    // Reset in the middle of the descrambling phase.
    rand_src(100);
    send_frame(7'h66, 100, 0, 30, 1'b1);
    drain();
    chk("pre_reset_locked", locked, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_last", last, 0);
    chk("arst_locked", locked, 0);
    chk("arst_serr", service_err, 0);
    chk("arst_lock_state", lock_state, 0);
    chk("arst_data", x_descrambled, 0);
    q.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    rand_src(120);
    send_frame(7'h2c, 120, 15, -1, 1'b0);
    drain();
    post_check(1'b1, f_lv, f_serr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
